// File: rtl/sig_capture_monitor.sv
// ---------------------------------------------------------------------------
// sig_capture_monitor: snoops core stores, queues signature words, ends run
// on halt store or watchdog.                               Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sig_capture_monitor #(
    parameter int             DW        = 32,
    parameter int             AW        = 32,
    parameter int             DEPTH     = 16,
    parameter logic [AW-1:0]  SIG_ADDR  = 'h00000f00,
    parameter logic [AW-1:0]  HALT_ADDR = 'hcafebeef,
    parameter int             TIMEOUT   = 500000,
    parameter int             CW        = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_wr,
    input  logic [AW-1:0]            mem_addr,
    input  logic [DW-1:0]            mem_wdata,
    input  logic                     sig_ready,
    output logic                     sig_valid,
    output logic [DW-1:0]            sig_data,
    output logic                     halted,
    output logic                     timed_out,
    output logic                     overflow,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   sig_count,
    output logic [CW-1:0]            cycles
);

    localparam int PW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;

    logic            in_run;
    logic            store;
    logic            sig_hit;
    logic            halt_hit;
    logic            expire;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    assign in_run   = (state == S_RUN);
    assign store    = ~mem_wr;
    assign sig_hit  = in_run && store && (mem_addr == SIG_ADDR);
    assign halt_hit = in_run && store && (mem_addr == HALT_ADDR);
    assign expire   = in_run && (cycles == CW'(TIMEOUT - 1));

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
    assign pop   = ~empty && sig_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO survives.
    assign push  = sig_hit && (~full || pop);
    assign drop  = sig_hit && full && ~pop;

    assign sig_valid = ~empty;
    assign sig_data  = empty ? '0 : mem[rptr[PW-2:0]];
    assign sig_count = wptr - rptr;
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[PW-2:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Halt wins over a coincident watchdog expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted    <= 1'b0;
            timed_out <= 1'b0;
            overflow  <= 1'b0;
            cycles    <= '0;
        end else begin
            if (in_run) begin
                cycles <= cycles + 1'b1;
            end
            if (halt_hit) begin
                halted <= 1'b1;
            end else if (expire) begin
                timed_out <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (halt_hit || expire) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sig_capture_monitor.sv
// ---------------------------------------------------------------------------
// tb_sig_capture_monitor: directed vectors and sequences for the monitor.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sig_capture_monitor;

    localparam int           DEPTH = 16;
    localparam logic [31:0]  SIGA  = 32'h00000f00;
    localparam logic [31:0]  HALTA = 32'hcafebeef;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        sig_ready;
    logic        sig_valid;
    logic [31:0] sig_data;
    logic        halted;
    logic        timed_out;
    logic        overflow;
    logic        done;
    logic [4:0]  sig_count;
    logic [19:0] cycles;

    int errors = 0;
    int checks = 0;

    sig_capture_monitor #(
        .DW(32), .AW(32), .DEPTH(DEPTH),
        .SIG_ADDR(SIGA), .HALT_ADDR(HALTA),
        .TIMEOUT(100), .CW(20)
    ) dut (
        .clk(clk), .rst(rst), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .sig_ready(sig_ready), .sig_valid(sig_valid),
        .sig_data(sig_data), .halted(halted), .timed_out(timed_out),
        .overflow(overflow), .done(done), .sig_count(sig_count), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_n;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_wr    = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_wr    = 1'b0;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        sig_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, SIGA,          32'h11, 1'b1, 1'b1, 32'h11, 5'd1};
        vecs[1] = '{1'b0, SIGA,          32'h22, 1'b1, 1'b1, 32'h22, 5'd1};
        vecs[2] = '{1'b0, SIGA,          32'h33, 1'b1, 1'b1, 32'h33, 5'd1};
        vecs[3] = '{1'b0, 32'h00001000,  32'h44, 1'b1, 1'b0, 32'h00, 5'd0};
        vecs[4] = '{1'b1, SIGA,          32'h55, 1'b1, 1'b0, 32'h00, 5'd0};
        vecs[5] = '{1'b0, SIGA,          32'h66, 1'b0, 1'b1, 32'h66, 5'd1};
        vecs[6] = '{1'b0, SIGA,          32'h77, 1'b0, 1'b1, 32'h66, 5'd2};
        vecs[7] = '{1'b1, 32'h0,         32'h00, 1'b1, 1'b1, 32'h77, 5'd1};
        vecs[8] = '{1'b1, 32'h0,         32'h00, 1'b1, 1'b0, 32'h00, 5'd0};

        rst = 1'b0;
        idle();
        sig_ready = 1'b0;
        #12;
        chk("rst_valid",   {31'd0, sig_valid}, 32'd0);
        chk("rst_data",    sig_data, 32'd0);
        chk("rst_flags",   {28'd0, halted, timed_out, overflow, done}, 32'd0);
        chk("rst_count",   {27'd0, sig_count}, 32'd0);
        chk("rst_cycles",  {12'd0, cycles}, 32'd0);

        // Basic capture / pop stream
        do_reset();
        for (int i = 0; i < 9; i++) begin
            mem_wr    = vecs[i].wr_n;
            mem_addr  = vecs[i].addr;
            mem_wdata = vecs[i].wdata;
            sig_ready = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, sig_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i), sig_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_count", i), {27'd0, sig_count}, {27'd0, vecs[i].exp_count});
            chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, 32'd0);
        end

        // Overflow: DEPTH+2 stores with no sink
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            store(SIGA, 32'h100 + i);
            step();
        end
        idle();
        chk("ovf_count", {27'd0, sig_count}, DEPTH);
        chk("ovf_flag",  {31'd0, overflow}, 32'd1);
        sig_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ovf_drain%0d", i), sig_data, 32'h100 + i);
            step();
        end
        chk("ovf_empty", {31'd0, sig_valid}, 32'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            store(SIGA, 32'h200 + i);
            step();
        end
        chk("full_count", {27'd0, sig_count}, DEPTH);
        store(SIGA, 32'h2ff);
        sig_ready = 1'b1;
        step();
        idle();
        chk("fullpp_count", {27'd0, sig_count}, DEPTH);
        chk("fullpp_ovf",   {31'd0, overflow}, 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("fullpp_drain%0d", i), sig_data, 32'h200 + i);
            step();
        end
        chk("fullpp_last", sig_data, 32'h2ff);
        step();
        chk("fullpp_empty", {31'd0, sig_valid}, 32'd0);

        // Halt with two words queued
        do_reset();
        store(SIGA, 32'ha1); step();
        store(SIGA, 32'ha2); step();
        store(HALTA, 32'hdead); step();
        chk("halt_flag",  {31'd0, halted}, 32'd1);
        chk("halt_done0", {31'd0, done}, 32'd0);
        chk("halt_count", {27'd0, sig_count}, 32'd2);
        store(SIGA, 32'hbb); step();
        idle();
        chk("halt_ignore", {27'd0, sig_count}, 32'd2);
        sig_ready = 1'b1;
        chk("halt_head0", sig_data, 32'ha1);
        step();
        chk("halt_head1", sig_data, 32'ha2);
        step();
        chk("halt_done_lag", {31'd0, done}, 32'd0);
        step();
        chk("halt_done1", {31'd0, done}, 32'd1);
        chk("halt_to0",   {31'd0, timed_out}, 32'd0);

        // Halt into an empty FIFO: done two cycles after the store
        do_reset();
        store(HALTA, 32'h0); step();
        idle();
        chk("hempty_d1", {31'd0, done}, 32'd0);
        step();
        chk("hempty_d2", {31'd0, done}, 32'd1);

        // Watchdog expiry
        do_reset();
        repeat (99) step();
        chk("wd_cyc99", {12'd0, cycles}, 32'd99);
        chk("wd_to99",  {31'd0, timed_out}, 32'd0);
        step();
        chk("wd_to",    {31'd0, timed_out}, 32'd1);
        chk("wd_cyc",   {12'd0, cycles}, 32'd100);
        chk("wd_done0", {31'd0, done}, 32'd0);
        step();
        chk("wd_done",  {31'd0, done}, 32'd1);
        store(SIGA, 32'h5); step(); step();
        idle();
        chk("wd_sat",   {12'd0, cycles}, 32'd100);
        chk("wd_noCap", {31'd0, sig_valid}, 32'd0);
        chk("wd_halt0", {31'd0, halted}, 32'd0);

        // Halt on the expiry cycle
        do_reset();
        repeat (99) step();
        store(HALTA, 32'h0); step();
        idle();
        chk("hx_halt", {31'd0, halted}, 32'd1);
        chk("hx_to",   {31'd0, timed_out}, 32'd0);
        chk("hx_cyc",  {12'd0, cycles}, 32'd100);

        // Asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            store(SIGA, 32'h300 + i);
            step();
        end
        store(HALTA, 32'h0); step();
        idle(); step();
        chk("ar_count5", {27'd0, sig_count}, 32'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", {31'd0, sig_valid}, 32'd0);
        chk("ar_done",  {31'd0, done}, 32'd0);
        chk("ar_count", {27'd0, sig_count}, 32'd0);
        chk("ar_halt",  {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        store(SIGA, 32'h77); step();
        idle();
        chk("ar_cap_valid", {31'd0, sig_valid}, 32'd1);
        chk("ar_cap_data",  sig_data, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
